// File: rtl/hue_stage0.sv
`default_nettype none
// ============================================================================
// Module   : hue_stage0
// Brief    : Hue pipeline front end. Finds max/min of an RGB pixel, picks the
//            dominant channel and emits dividend, divisor and function code
//            for hue_stage1. Fixed 2-cycle latency, full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module hue_stage0 #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_red,
  input  logic [DATA_WIDTH-1:0] i_green,
  input  logic [DATA_WIDTH-1:0] i_blue,
  input  logic [USER_WIDTH-1:0] i_user,
  input  logic                  i_valid,
  output logic [DATA_WIDTH:0]   o_dividend,
  output logic [DATA_WIDTH:0]   o_divisor,
  output logic [1:0]            o_function,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [USER_WIDTH-1:0] o_user,
  output logic                  o_valid
);

  // Channel-select codes double as the function code emitted downstream.
  localparam logic [1:0] c_fn_achrom = 2'd0;
  localparam logic [1:0] c_sel_red   = 2'd1;
  localparam logic [1:0] c_sel_green = 2'd2;
  localparam logic [1:0] c_sel_blue  = 2'd3;

  // Stage A registers
  logic [DATA_WIDTH-1:0] a_red_q, a_red_d;
  logic [DATA_WIDTH-1:0] a_green_q, a_green_d;
  logic [DATA_WIDTH-1:0] a_blue_q, a_blue_d;
  logic [DATA_WIDTH-1:0] a_max_q, a_max_d;
  logic [DATA_WIDTH-1:0] a_min_q, a_min_d;
  logic [1:0]            a_sel_q, a_sel_d;
  logic [USER_WIDTH-1:0] a_user_q, a_user_d;
  logic                  a_valid_q, a_valid_d;

  // Stage B registers
  logic [DATA_WIDTH:0]   b_dividend_q, b_dividend_d;
  logic [DATA_WIDTH:0]   b_divisor_q, b_divisor_d;
  logic [1:0]            b_function_q, b_function_d;
  logic [DATA_WIDTH-1:0] b_max_q, b_max_d;
  logic [USER_WIDTH-1:0] b_user_q, b_user_d;
  logic                  b_valid_q, b_valid_d;

  logic [DATA_WIDTH-1:0] w_max;
  logic [DATA_WIDTH-1:0] w_min;
  logic [1:0]            w_sel;
  logic [DATA_WIDTH:0]   w_delta;
  logic [DATA_WIDTH:0]   w_diff;

  // Max with fixed red > green > blue tie-break priority; plain 3-way min.
  always_comb begin
    w_sel = c_sel_blue;
    w_max = i_blue;
    if ((i_red >= i_green) && (i_red >= i_blue)) begin
      w_sel = c_sel_red;
      w_max = i_red;
    end else if (i_green >= i_blue) begin
      w_sel = c_sel_green;
      w_max = i_green;
    end
    w_min = i_red;
    if (i_green < w_min) w_min = i_green;
    if (i_blue < w_min)  w_min = i_blue;
  end

  // Stage A next state: valid always shifts, data only captured on valid.
  always_comb begin
    a_red_d   = a_red_q;
    a_green_d = a_green_q;
    a_blue_d  = a_blue_q;
    a_max_d   = a_max_q;
    a_min_d   = a_min_q;
    a_sel_d   = a_sel_q;
    a_user_d  = a_user_q;
    a_valid_d = i_valid;
    if (i_valid) begin
      a_red_d   = i_red;
      a_green_d = i_green;
      a_blue_d  = i_blue;
      a_max_d   = w_max;
      a_min_d   = w_min;
      a_sel_d   = w_sel;
      a_user_d  = i_user;
    end
  end

  // Differences on zero-extended operands; max-min never goes negative.
  always_comb begin
    w_delta = {1'b0, a_max_q} - {1'b0, a_min_q};
    case (a_sel_q)
      c_sel_red:   w_diff = {1'b0, a_green_q} - {1'b0, a_blue_q};
      c_sel_green: w_diff = {1'b0, a_blue_q} - {1'b0, a_red_q};
      default:     w_diff = {1'b0, a_red_q} - {1'b0, a_green_q};
    endcase
  end

  // Stage B next state: achromatic pixels force all-zero arithmetic outputs.
  always_comb begin
    b_dividend_d = b_dividend_q;
    b_divisor_d  = b_divisor_q;
    b_function_d = b_function_q;
    b_max_d      = b_max_q;
    b_user_d     = b_user_q;
    b_valid_d    = a_valid_q;
    if (a_valid_q) begin
      b_max_d  = a_max_q;
      b_user_d = a_user_q;
      if (w_delta == '0) begin
        b_dividend_d = '0;
        b_divisor_d  = '0;
        b_function_d = c_fn_achrom;
      end else begin
        b_dividend_d = w_diff;
        b_divisor_d  = w_delta;
        b_function_d = a_sel_q;
      end
    end
  end

  // Pipeline registers; reset clears every stage and discards in-flight pixels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_red_q      <= '0;
      a_green_q    <= '0;
      a_blue_q     <= '0;
      a_max_q      <= '0;
      a_min_q      <= '0;
      a_sel_q      <= '0;
      a_user_q     <= '0;
      a_valid_q    <= 1'b0;
      b_dividend_q <= '0;
      b_divisor_q  <= '0;
      b_function_q <= '0;
      b_max_q      <= '0;
      b_user_q     <= '0;
      b_valid_q    <= 1'b0;
    end else begin
      a_red_q      <= a_red_d;
      a_green_q    <= a_green_d;
      a_blue_q     <= a_blue_d;
      a_max_q      <= a_max_d;
      a_min_q      <= a_min_d;
      a_sel_q      <= a_sel_d;
      a_user_q     <= a_user_d;
      a_valid_q    <= a_valid_d;
      b_dividend_q <= b_dividend_d;
      b_divisor_q  <= b_divisor_d;
      b_function_q <= b_function_d;
      b_max_q      <= b_max_d;
      b_user_q     <= b_user_d;
      b_valid_q    <= b_valid_d;
    end
  end

  assign o_dividend = b_dividend_q;
  assign o_divisor  = b_divisor_q;
  assign o_function = b_function_q;
  assign o_max      = b_max_q;
  assign o_user     = b_user_q;
  assign o_valid    = b_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_hue_stage0.sv
`default_nettype none
// ============================================================================
// Module   : tb_hue_stage0
// Brief    : Scoreboard bench for hue_stage0: directed and random pixels,
//            valid gaps, and reset mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hue_stage0;

  localparam int DW = 8;
  localparam int UW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_red, i_green, i_blue;
  logic [UW-1:0] i_user;
  logic          i_valid;
  logic [DW:0]   o_dividend, o_divisor;
  logic [1:0]    o_function;
  logic [DW-1:0] o_max;
  logic [UW-1:0] o_user;
  logic          o_valid;

  hue_stage0 #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_red      (i_red),
    .i_green    (i_green),
    .i_blue     (i_blue),
    .i_user     (i_user),
    .i_valid    (i_valid),
    .o_dividend (o_dividend),
    .o_divisor  (o_divisor),
    .o_function (o_function),
    .o_max      (o_max),
    .o_user     (o_user),
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW:0]   dividend;
    logic [DW:0]   divisor;
    logic [1:0]    fn;
    logic [DW-1:0] mx;
    logic [UW-1:0] user;
    int            tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_issued = 0;
  int   n_seen = 0;
  int   cyc = 0;
  logic [UW-1:0] user_ctr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: hue front-end rules written with plain integer arithmetic.
  function automatic exp_t model(input int r, input int g, input int b, input logic [UW-1:0] u);
    exp_t e;
    int mx, mn, d, fn;
    if (r >= g && r >= b) begin mx = r; fn = 1; d = g - b; end
    else if (g >= b)      begin mx = g; fn = 2; d = b - r; end
    else                  begin mx = b; fn = 3; d = r - g; end
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    if (mx == mn) begin fn = 0; d = 0; end
    e.dividend = d[DW:0];
    e.divisor  = 9'(mx - mn);
    e.fn       = fn[1:0];
    e.mx       = mx[DW-1:0];
    e.user     = u;
    e.tag      = 0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one pixel after the edge; push its expected result if it is valid.
  task automatic send(input logic [DW-1:0] r, g, b, input logic v,
                      input logic use_dir, input exp_t dir);
    exp_t e;
    @(posedge clk); #1;
    i_red = r; i_green = g; i_blue = b; i_valid = v; i_user = user_ctr;
    if (v) begin
      e = use_dir ? dir : model(int'(r), int'(g), int'(b), user_ctr);
      e.user = user_ctr;
      e.tag  = cyc;
      exp_q.push_back(e);
      n_issued++;
      user_ctr = user_ctr + 1'b1;
    end
  endtask

  task automatic send_dir(input logic [DW-1:0] r, g, b,
                          input logic [DW:0] dvd, dvs, input logic [1:0] fn);
    exp_t d;
    d.dividend = dvd; d.divisor = dvs; d.fn = fn; d.mx = '0; d.user = '0; d.tag = 0;
    d.mx = (r >= g && r >= b) ? r : ((g >= b) ? g : b);
    send(r, g, b, 1'b1, 1'b1, d);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"},    o_valid, 0);
    check({name, "_dividend"}, o_dividend, 0);
    check({name, "_divisor"},  o_divisor, 0);
    check({name, "_function"}, o_function, 0);
    check({name, "_max"},      o_max, 0);
    check({name, "_user"},     o_user, 0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a valid output.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency",  cyc - e.tag, 2);
        check("dividend", o_dividend, e.dividend);
        check("divisor",  o_divisor, e.divisor);
        check("function", o_function, e.fn);
        check("max",      o_max, e.mx);
        check("user",     o_user, e.user);
      end
    end
  end

  initial begin
    exp_t none;
    none.dividend = '0; none.divisor = '0; none.fn = '0; none.mx = '0; none.user = '0; none.tag = 0;
    rst = 1'b1; i_valid = 1'b1; i_red = 8'd77; i_green = 8'd12; i_blue = 8'd200; i_user = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;

    // Directed pixels: one per dominant channel, tie-breaks, achromatic.
    send_dir(8'd200, 8'd50,  8'd100, 9'h1CE, 9'd150, 2'd1);
    send_dir(8'd10,  8'd240, 8'd30,  9'd20,  9'd230, 2'd2);
    send_dir(8'd0,   8'd5,   8'd90,  9'h1FB, 9'd90,  2'd3);
    send_dir(8'd255, 8'd255, 8'd0,   9'd255, 9'd255, 2'd1);
    send_dir(8'd0,   8'd255, 8'd255, 9'd255, 9'd255, 2'd2);
    send_dir(8'd128, 8'd128, 8'd128, 9'd0,   9'd0,   2'd0);
    send_dir(8'd0,   8'd0,   8'd0,   9'd0,   9'd0,   2'd0);
    send_dir(8'd255, 8'd255, 8'd255, 9'd0,   9'd0,   2'd0);
    send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, none);

    // 64 back-to-back random pixels.
    for (int i = 0; i < 64; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, none);

    // Random valid gaps, with occasional low-entropy channels to hit ties.
    for (int i = 0; i < 96; i++) begin
      logic [DW-1:0] r, g, b;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = 8'($urandom_range(0, 2)); g = 8'($urandom_range(0, 2)); b = 8'($urandom_range(0, 2));
      end
      send(r, g, b, 1'($urandom_range(0, 1)), 1'b0, none);
    end

    // Reset mid-stream with a valid pixel on the reset edge.
    for (int i = 0; i < 4; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, none);
    @(posedge clk); #1;
    rst = 1'b1; i_valid = 1'b1; i_red = 8'd9; i_green = 8'd99; i_blue = 8'd199;
    @(posedge clk); #1;
    n_issued -= exp_q.size();
    exp_q.delete();
    rst = 1'b0;
    begin
      exp_t e;
      e = model(33, 66, 11, user_ctr);
      e.tag = cyc;
      i_red = 8'd33; i_green = 8'd66; i_blue = 8'd11; i_user = user_ctr; i_valid = 1'b1;
      exp_q.push_back(e);
      n_issued++;
      user_ctr = user_ctr + 1'b1;
    end
    @(negedge clk);
    check_zero_outputs("post_reset");
    for (int i = 0; i < 20; i++)
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, none);

    // Drain.
    for (int i = 0; i < 4; i++)
      send(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, none);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("valid_count", n_seen, n_issued);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hue_stage0.md
# hue_stage0

Front end of the hue pipeline. Accepts one RGB pixel per cycle, finds the max and min channels, and classifies the pixel by which channel is the maximum. It emits the signed dividend, unsigned divisor and function code that `hue_stage1` consumes. Fixed 2-cycle latency at full throughput, with a user sideband carried alongside. It sits between the pixel source and `hue_stage1`; its outputs connect port-for-port to `hue_stage1` inputs.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: bits per colour channel.
- `USER_WIDTH`, default 2: sideband width, for example start-of-frame and end-of-line. It is delayed unchanged.

**Ports**
- `i_clk` — in, 1: clock. All logic is on the rising edge.
- `i_rst` — in, 1: reset. Synchronous, active-high.
- `i_red`, `i_green`, `i_blue` — in, DATA_WIDTH each: pixel channels, unsigned.
- `i_user` — in, USER_WIDTH: sideband. Sampled only when `i_valid`=1.
- `i_valid` — in, 1: pixel qualifier. There is no backpressure.
- `o_dividend` — out, DATA_WIDTH+1: two's-complement channel difference.
- `o_divisor` — out, DATA_WIDTH+1: max−min, zero-extended.
- `o_function` — out, 2: 0 = achromatic, 1 = red max, 2 = green max, 3 = blue max.
- `o_max` — out, DATA_WIDTH: max channel (HSV value), for downstream saturation/value.
- `o_user` — out, USER_WIDTH: delayed `i_user`.
- `o_valid` — out, 1: output qualifier.

## Operation

**Stage A (register 1)**
- Capture R, G, B, user and valid.
- Compute max, min and a 2-bit `max_sel`. Tie-break is fixed:
  - red if R≥G and R≥B;
  - else green if G≥B;
  - else blue.
- Min is a plain 3-way minimum. Ties do not matter for min.

**Stage B (register 2)**
- delta = max − min. It is always ≥ 0, so no sign handling is needed.
- `max_sel` = red: dividend = G − B, function = 1.
- `max_sel` = green: dividend = B − R, function = 2.
- `max_sel` = blue: dividend = R − G, function = 3.
- delta = 0 overrides all three cases: function = 0, dividend = 0, divisor = 0. `o_max` still equals the channel value.

**Arithmetic**
- Subtractions are done at DATA_WIDTH+1 bits on zero-extended operands.
- The result range is −(2^DATA_WIDTH−1)…+(2^DATA_WIDTH−1), so no overflow is possible.

**Invalid cycles**
- Cycles with `i_valid`=0 still shift through the pipeline.
- Data registers hold their previous contents on those cycles. Downstream must ignore data when `o_valid`=0.
- Registering data only on valid is permitted for power.
- `o_valid` is a pure 2-cycle delay of `i_valid`.

## Timing

- **Latency:** exactly 2 cycles, `i_valid` at edge N → `o_valid` at edge N+2.
- **Throughput:** one pixel per cycle, back-to-back, with no bubbles inserted.
- **Alignment:** `o_user`, `o_max`, `o_dividend`, `o_divisor` and `o_function` are all aligned with `o_valid`.
- **Reset values:** while `i_rst` is asserted, every output and every internal pipeline register is 0. This includes `o_valid`=0 and `o_function`=0.
- **Reset mid-stream:** asserting `i_rst` on any edge discards all in-flight pixels.
  - The first `o_valid` after release is for a pixel presented on or after the first non-reset edge.
  - It appears 2 cycles after that pixel.
- **Simultaneous reset and valid:** `i_rst` dominates and the pixel is dropped.
- **No combinational paths** from inputs to outputs.

## Test plan

- **Single-channel max, one per channel:**
  - R=200, G=50, B=100 → dividend 9'h1CE (−50), divisor 150, function 1, max 200.
  - R=10, G=240, B=30 → dividend 20, divisor 230, function 2.
  - R=0, G=5, B=90 → dividend −5 (9'h1FB), divisor 90, function 3.
  - Each with `o_valid` exactly 2 cycles after input.
- **Tie-breaks:**
  - R=255, G=255, B=0 → function 1, dividend 255, divisor 255.
  - R=0, G=255, B=255 → function 2, dividend 255, divisor 255.
- **Achromatic:** R=G=B=128 → function 0, dividend 0, divisor 0, max 128. Also R=G=B=0 and R=G=B=255 → function 0.
- **Throughput and sideband:** 64 back-to-back random pixels with incrementing `i_user`.
  - Every output must match a reference model, in order, with 2-cycle lag and no gaps.
  - Then repeat with random `i_valid` gaps: only valid pixels are compared and the `o_valid` count equals the `i_valid` count.
- **Reset mid-stream:** stream pixels, assert `i_rst` for 1 cycle with `i_valid`=1.
  - Outputs read 0 on the following edge.
  - No pre-reset pixel emerges.
  - The first post-reset pixel appears 2 cycles after it is presented.
- **Integration:** drive `hue_stage0` into `hue_stage1` (DIVIDE_LATENCY=16) with the single-channel pixels above. The end-to-end `o_valid` count and order must match the input, and achromatic pixels must pass through without hanging the divider.
